// File: rtl/minmax_tree_scheduler.sv
// -----------------------------------------------------------------------------
// minmax_tree_scheduler
//
// Shares one pipelined NUM_INPUTS-operand min/max reduction tree between
// NUM_REQ requesters. Each enabled cycle a round-robin arbiter picks one valid
// requester and forwards its operand vector to the tree. A shadow valid/ID
// pipeline, as deep as the tree, follows each vector so that the result can
// be returned tagged with the ID of the requester that issued it.
//
// Back-pressure on the response port freezes the tree and the shadow pipeline
// together through io_tree_start. The result therefore stays put until it is
// accepted.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   io_req_valid    [NUM_REQ]        per-requester request valid
//   io_req_ready    [NUM_REQ]        per-requester accept (one-hot or zero)
//   io_req_data     [NUM_REQ*SLICE]  requester r at slice r; operand k at
//                                    [k*WIDTH +: WIDTH] inside that slice
//   io_tree_start   global stage enable to the tree
//   io_tree_inputs  [SLICE]          operands to the tree (zero on a bubble)
//   io_tree_result  [WIDTH]          tree output register
//   io_resp_valid   result available
//   io_resp_ready   consumer accepts the result
//   io_resp_data    [WIDTH]          result (pass-through of io_tree_result)
//   io_resp_id      [ID_W]           requester that issued the result
//   io_inflight     [clog2(LAT+1)]   number of live entries in the pipeline
// -----------------------------------------------------------------------------
module minmax_tree_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_INPUTS = 6,
  parameter int WIDTH      = 7,
  parameter int LATENCY    = 3,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    io_req_valid,
  output logic [NUM_REQ-1:0]                    io_req_ready,
  input  logic [NUM_REQ*NUM_INPUTS*WIDTH-1:0]   io_req_data,
  output logic                                  io_tree_start,
  output logic [NUM_INPUTS*WIDTH-1:0]           io_tree_inputs,
  input  logic [WIDTH-1:0]                      io_tree_result,
  output logic                                  io_resp_valid,
  input  logic                                  io_resp_ready,
  output logic [WIDTH-1:0]                      io_resp_data,
  output logic [ID_W-1:0]                       io_resp_id,
  output logic [$clog2(LATENCY+1)-1:0]          io_inflight
);

  localparam int SLICE = NUM_INPUTS * WIDTH;
  localparam int CNT_W = $clog2(LATENCY + 1);

  // Shadow pipeline: one valid bit and one requester ID per tree stage.
  // Stage LATENCY-1 lines up with the tree output register.
  logic [LATENCY-1:0]           vld_pipe;
  logic [LATENCY-1:0][ID_W-1:0] id_pipe;

  logic [ID_W-1:0] ptr;      // highest-priority requester for the next pick
  logic [ID_W-1:0] winner;
  logic            issue;
  logic            stall;
  logic            start;

  // ---------------------------------------------------------------------------
  // Stall / stage enable
  // ---------------------------------------------------------------------------
  // The tree and the shadow pipeline can only advance if the head result
  // either is a bubble or is being accepted in this cycle. While reset is
  // high the enable is forced on, so the tree keeps flushing. The stale
  // contents it carries are never reported because the valid bits are
  // cleared.
  always_comb begin
    stall = vld_pipe[LATENCY-1] & ~io_resp_ready;
    start = reset | ~stall;
  end

  assign io_tree_start = start;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  // Scan the requesters starting at ptr and wrap modulo NUM_REQ. The first
  // requester with valid set wins. Only the winner's slice reaches the tree.
  // In every other cycle the tree sees zeros, and that bubble carries v=0.
  always_comb begin
    int j;
    io_req_ready   = '0;
    io_tree_inputs = '0;
    winner         = '0;
    issue          = 1'b0;
    j              = 0;
    if (!reset && !stall) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        j = int'(ptr) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!issue && io_req_valid[j]) begin
          issue          = 1'b1;
          winner         = ID_W'(j);
          io_req_ready[j] = 1'b1;
          io_tree_inputs = io_req_data[j*SLICE +: SLICE];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow pipeline and pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
      ptr      <= '0;
    end else begin
      if (start) begin
        vld_pipe[0] <= issue;
        id_pipe[0]  <= winner;
        for (int k = 1; k < LATENCY; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          id_pipe[k]  <= id_pipe[k-1];
        end
      end
      // After a grant, the requester just past the winner gets top priority.
      if (issue) begin
        ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response port and occupancy
  // ---------------------------------------------------------------------------
  assign io_resp_valid = vld_pipe[LATENCY-1];
  assign io_resp_id    = id_pipe[LATENCY-1];
  assign io_resp_data  = io_tree_result;

  always_comb begin
    io_inflight = '0;
    for (int k = 0; k < LATENCY; k++) begin
      io_inflight = io_inflight + CNT_W'(vld_pipe[k]);
    end
  end

endmodule

// File: tb/tb_minmax_tree_scheduler.sv
// -----------------------------------------------------------------------------
// tb_minmax_tree_scheduler
//
// Wraps the scheduler around a behavioural LATENCY-stage min tree.
//
// A cycle-level reference model runs on the falling edge. It works from
// high-level rules: round-robin fairness, a queue of in-flight vectors with
// due times counted in enabled edges, and min() of each issued vector. The
// model predicts grants, stall, response valid and occupancy. For every
// issue it pushes the expected {id, min} into a scoreboard.
//
// A separate monitor compares every presented response against the head of
// the scoreboard and pops the head on acceptance.
// -----------------------------------------------------------------------------
module tb_minmax_tree_scheduler;

  localparam int NR  = 4;
  localparam int NI  = 6;
  localparam int W   = 7;
  localparam int L   = 3;
  localparam int IDW = $clog2(NR);
  localparam int CW  = $clog2(L + 1);

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NR-1:0]        io_req_valid;
  logic [NR-1:0]        io_req_ready;
  logic [NR*NI*W-1:0]   io_req_data;
  logic                 io_tree_start;
  logic [NI*W-1:0]      io_tree_inputs;
  logic [W-1:0]         io_tree_result;
  logic                 io_resp_valid;
  logic                 io_resp_ready;
  logic [W-1:0]         io_resp_data;
  logic [IDW-1:0]       io_resp_id;
  logic [CW-1:0]        io_inflight;

  minmax_tree_scheduler #(
    .NUM_REQ(NR), .NUM_INPUTS(NI), .WIDTH(W), .LATENCY(L)
  ) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_data(io_req_data),
    .io_tree_start(io_tree_start), .io_tree_inputs(io_tree_inputs),
    .io_tree_result(io_tree_result),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data), .io_resp_id(io_resp_id),
    .io_inflight(io_inflight)
  );

  always #5 clock = ~clock;

  // Requester operand vectors, packed onto io_req_data.
  logic [W-1:0] vec [NR][NI];
  always_comb begin
    io_req_data = '0;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NI; k++)
        io_req_data[(r*NI+k)*W +: W] = vec[r][k];
  end

  // External min tree. It is an L-stage enabled pipeline: the first stage
  // captures the inputs and the last stage is the output register.
  logic [W-1:0] tstage [L];
  always @(posedge clock) begin
    if (io_tree_start) begin
      logic [W-1:0] m;
      m = io_tree_inputs[W-1:0];
      for (int k = 1; k < NI; k++)
        if (io_tree_inputs[k*W +: W] < m) m = io_tree_inputs[k*W +: W];
      tstage[0] <= m;
      for (int k = 1; k < L; k++) tstage[k] <= tstage[k-1];
    end
  end
  assign io_tree_result = tstage[L-1];

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int min_of(input int r);
    int m;
    m = int'(vec[r][0]);
    for (int k = 1; k < NI; k++) if (int'(vec[r][k]) < m) m = int'(vec[r][k]);
    return m;
  endfunction

  typedef struct { int id; int data; } exp_t;
  exp_t sb[$];      // expected responses, in order
  int   mq[$];      // due time (in enabled edges) of each in-flight vector
  int   mptr;
  int   ecount;

  // ---------------------------------------------------------------------------
  // Reference model: predicts control outputs and produces expected results
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    bit            pv, st;
    int            g;
    logic [NR-1:0] eg;
    if (reset) begin
      check("reset_req_ready", io_req_ready, 0);
      check("reset_tree_start", io_tree_start, 1);
      mq.delete();
      mptr   = 0;
      ecount = 0;
    end else begin
      pv = (mq.size() > 0) && (mq[0] == ecount);
      st = pv && !io_resp_ready;
      g  = -1;
      eg = '0;
      if (!st)
        for (int i = 0; i < NR; i++)
          if (g < 0 && io_req_valid[(mptr + i) % NR]) g = (mptr + i) % NR;
      if (g >= 0) eg[g] = 1'b1;
      check("resp_valid", io_resp_valid, pv);
      check("tree_start", io_tree_start, !st);
      check("req_ready", io_req_ready, eg);
      check("inflight", io_inflight, mq.size());
      if (g < 0) check("bubble_inputs", io_tree_inputs, 0);
      if (pv && io_resp_ready) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back(ecount + L);
        sb.push_back('{g, min_of(g)});
        mptr = (g + 1) % NR;
      end
      if (!st) ecount++;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares whatever the DUT presents against the scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clock) begin
    #1;
    if (reset) sb.delete();
    else if (io_resp_valid) begin
      check("resp_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        check("resp_data", io_resp_data, sb[0].data);
        check("resp_id", io_resp_id, sb[0].id);
        if (io_resp_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (all tasks start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic new_vec(input int r);
    for (int k = 0; k < NI; k++) vec[r][k] = W'($urandom);
  endtask

  // One clock. A requester that was accepted, or that is idle, draws a fresh
  // request with probability req_pct. The consumer is ready with
  // probability rdy_pct.
  task automatic drive(input int req_pct, input int rdy_pct);
    logic [NR-1:0] acc;
    @(negedge clock);
    acc = io_req_valid & io_req_ready;
    @(posedge clock);
    #1;
    for (int r = 0; r < NR; r++) begin
      if (!io_req_valid[r] || acc[r]) begin
        io_req_valid[r] = (int'($urandom_range(99)) < req_pct);
        if (io_req_valid[r]) new_vec(r);
      end
    end
    io_resp_ready = (int'($urandom_range(99)) < rdy_pct);
  endtask

  task automatic one_shot(input int r);
    new_vec(r);
    io_req_valid[r] = 1'b1;
    drive(0, 100);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 100);
  endtask

  task automatic do_reset(input int n);
    reset        = 1'b1;
    io_req_valid = '0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    io_req_valid  = '0;
    io_resp_ready = 1'b1;
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NI; k++) vec[r][k] = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single request from requester 2: the expected min is 12, with id 2.
    vec[2] = '{7'd50, 7'd12, 7'd90, 7'd33, 7'd70, 7'd41};
    io_req_valid[2] = 1'b1;
    drive(0, 100);
    idle(6);

    // All requesters saturated: grants rotate and responses stream back.
    io_req_valid = '1;
    for (int r = 0; r < NR; r++) new_vec(r);
    repeat (10) drive(100, 100);

    // Back-pressure with the pipeline full, then release.
    repeat (5) drive(100, 0);
    repeat (3) drive(100, 100);
    io_req_valid = '0;
    idle(6);

    // Wrap: after requester 1 the pointer sits at 2, so 3 goes before 1.
    one_shot(1);
    new_vec(1);
    new_vec(3);
    io_req_valid[1] = 1'b1;
    io_req_valid[3] = 1'b1;
    idle(8);

    // Reset with two vectors in flight, then a clean request from 0.
    one_shot(0);
    one_shot(1);
    do_reset(2);
    idle(2);
    one_shot(0);
    idle(6);

    // Sparse traffic: one request every 4 cycles.
    for (int n = 0; n < 6; n++) begin
      one_shot(int'($urandom_range(NR - 1)));
      idle(3);
    end

    // Random traffic with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      int rq, rd;
      rq = int'($urandom_range(90, 20));
      rd = int'($urandom_range(100, 30));
      repeat (10) drive(rq, rd);
    end

    // Drain everything that is still pending.
    idle(12);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/minmax_tree_scheduler.md
Name: minmax_tree_scheduler

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 6-input, 7-bit min/max reduction tree between NUM_REQ requesters (fuzzification rule engines).
- Accepts one input vector per cycle via valid/ready and drives the tree's inputs and global stage enable (`start`).
- Tracks in-flight vectors with a shadow valid/ID pipeline matched to tree latency.
- Returns each result with its requester ID over a valid/ready response port, stalling the whole tree on back-pressure.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_INPUTS, 6, operands per vector, equal to tree input count.
- WIDTH, 7, operand/result width in bits.
- LATENCY, 3, tree depth in enabled clock edges from input capture to `io_tree_result` valid.
- ID_W, clog2(NUM_REQ), response ID width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- io_req_valid  in  NUM_REQ  per-requester request valid.
- io_req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- io_req_data  in  NUM_REQ*NUM_INPUTS*WIDTH  requester r occupies slice r; operand k at bits [k*WIDTH +: WIDTH] within that slice.
- io_tree_start  out  1  global stage enable to the tree.
- io_tree_inputs  out  NUM_INPUTS*WIDTH  operands to the tree.
- io_tree_result  in  WIDTH  tree output register.
- io_resp_valid  out  1  result available.
- io_resp_ready  in  1  consumer accepts the result.
- io_resp_data  out  WIDTH  result, equal to io_tree_result.
- io_resp_id  out  ID_W  requester that issued this result.
- io_inflight  out  clog2(LATENCY+1)  count of valid entries in the shadow pipeline.

Behaviour:
- stall = io_resp_valid & ~io_resp_ready; io_tree_start = ~stall. The tree and shadow pipeline freeze together, so io_tree_result stays stable while stalled.
- Shadow pipeline: v[0..LATENCY-1] and id[0..LATENCY-1].
  - On start: v[0] <= issue, id[0] <= grant index, v[k] <= v[k-1], id[k] <= id[k-1].
  - Otherwise all hold.
- io_resp_valid = v[LATENCY-1]; io_resp_id = id[LATENCY-1]; io_resp_data = io_tree_result (combinational pass-through).
- Arbitration (combinational, only when ~stall):
  - Search io_req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first set bit wins; io_req_ready[winner] = 1 and all others 0.
  - issue = any valid & ~stall.
  - When stalled, all io_req_ready = 0.
- ptr update: on issue, ptr <= winner+1, wrapping NUM_REQ-1 -> 0. Otherwise ptr holds.
- io_tree_inputs = winner's io_req_data slice on issue, else all zeros. The resulting bubble has v=0 and is never reported.
- Throughput: one issue per enabled cycle, with no gaps between back-to-back issues.
- Latency: a vector accepted at edge t gives io_resp_valid high after edge t+LATENCY-1, when there is no stall.
- Response and new issue in the same cycle are both allowed: resp fires and the pipeline advances.
- Back-pressure: the response holds, stable in data and ID, until io_resp_ready. No result is dropped or duplicated.
- io_inflight = popcount(v), updated each cycle.
- Reset (including mid-operation):
  - v cleared, ptr = 0, so io_resp_valid = 0 and io_inflight = 0 in the cycle after reset.
  - io_req_ready follows io_req_valid from index 0 while reset is low.
  - Tree registers are not reset; stale tree contents never surface because v = 0.
  - During reset high, io_req_ready = 0 and io_tree_start = 1.

Test Plan:
- Single request; bench uses 6-input 7-bit min tree. Requester 2 sends {50,12,90,33,70,41} with io_resp_ready=1 -> accepted next edge, ready[2]=1 only; io_resp_valid=1 with data=12, id=2 exactly LATENCY-1 edges later, one cycle wide.
- All four requesters valid continuously, io_resp_ready=1 -> grants cycle 2? No: grants cycle 0,1,2,3,0,1... with ptr starting 0; responses arrive back-to-back in the same ID order; 8 results in 8 consecutive cycles.
- Back-pressure: 3 vectors in flight, io_resp_ready=0 for 5 cycles -> io_tree_start=0, all io_req_ready=0, io_resp_data/id constant, io_inflight=3. Release -> the 3 results drain in order with no loss.
- Requester 1 vector in flight, then requesters 1 and 3 valid with ptr=2 -> grant 3 first, then 1; ptr wraps 3->0.
- Reset asserted with 2 in flight -> io_resp_valid=0 and io_inflight=0 after release. Next request from requester 0 returns its correct min with id=0; no stale response appears.
- Sparse traffic, one request every 4 cycles -> bubbles are never reported; io_inflight never exceeds 1.
